// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: state encoding and width helper.
// Kept in a package so a future read-side scheduler can reuse the same encodings.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Minimum of one bit so degenerate widths never collapse to zero.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching ptr, ptr+1, ... mod N_REQ.
// Index wrap uses an explicit compare so non-power-of-two N_REQ works.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic [clog2(N_REQ)-1:0] idx,
    output logic                    found
);

    localparam int PW = clog2(N_REQ);

    logic [PW:0]   cand_sum [N_REQ];
    logic [PW-1:0] cand     [N_REQ];
    logic [N_REQ-1:0] hit;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr} + (PW+1)'(gi);
            assign cand[gi] = (cand_sum[gi] >= (PW+1)'(N_REQ))
                            ? PW'(cand_sum[gi] - (PW+1)'(N_REQ))
                            : cand_sum[gi][PW-1:0];
            assign hit[gi] = req[cand[gi]];
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the fifo_syn write port between N_REQ producers.
// One arbitration cycle in IDLE, then up to MAX_BURST zero-latency beats from the owner.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    input  logic                      fifo_full,
    input  logic                      fifo_threshold,
    output logic                      fifo_wen,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [clog2(N_REQ)-1:0]   owner,
    output logic                      busy
);

    localparam int OW = clog2(N_REQ);
    localparam int CW = clog2(MAX_BURST + 1);

    arb_state_t    state_reg, state_next;
    logic [OW-1:0] owner_reg, owner_next;
    logic [OW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0] burst_cnt_reg, burst_cnt_next;

    logic [OW-1:0]     pick_idx;
    logic              pick_found;
    logic [OW-1:0]     owner_succ;
    logic [DATA_W-1:0] slice [N_REQ];
    logic              owner_gnt;
    logic              accept;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .found (pick_found)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign slice[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign owner_succ = (owner_reg == OW'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        gnt            = '0;
        fifo_wen       = 1'b0;
        fifo_data      = '0;
        owner_gnt      = 1'b0;
        accept         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next     = ST_BURST;
                    owner_next     = pick_idx;
                    burst_cnt_next = '0;
                end
            end
            ST_BURST: begin
                // Reset gating keeps a mid-burst reset from writing a partial beat.
                owner_gnt       = ~fifo_full & ~rst;
                gnt[owner_reg]  = owner_gnt;
                accept          = req[owner_reg] & owner_gnt;
                fifo_wen        = accept;
                fifo_data       = accept ? slice[owner_reg] : '0;
                if (!req[owner_reg]) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = owner_succ;
                end else if (accept) begin
                    if (burst_cnt_reg == CW'(MAX_BURST - 1) || fifo_threshold) begin
                        state_next  = ST_IDLE;
                        rr_ptr_next = owner_succ;
                    end else begin
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    assign owner = owner_reg;
    assign busy  = (state_reg == ST_BURST);

endmodule
